// File: rtl/rfid_pkg.sv
// Shared encodings for the Gen2 tag inventory controller: states, command codes,
// reply types and field bit positions inside the MSB-aligned command data.
package rfid_pkg;

    typedef enum logic [2:0] {
        ST_READY        = 3'd0,
        ST_ARBITRATE    = 3'd1,
        ST_REPLY        = 3'd2,
        ST_ACKNOWLEDGED = 3'd3,
        ST_OPEN         = 3'd4
    } tag_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_QUERY_REP,
        CMD_ACK,
        CMD_QUERY,
        CMD_QUERY_ADJUST,
        CMD_NAK,
        CMD_REQ_RN
    } cmd_kind_t;

    typedef enum logic [1:0] {
        REPLY_RN16   = 2'd0,
        REPLY_EPC    = 2'd1,
        REPLY_HANDLE = 2'd2
    } reply_type_t;

    localparam logic [1:0] CLASS_CMD2 = 2'd0;
    localparam logic [1:0] CLASS_CMD4 = 2'd1;
    localparam logic [1:0] CLASS_CMD8 = 2'd2;

    localparam logic [1:0] CODE_QUERY_REP    = 2'b00;
    localparam logic [1:0] CODE_ACK          = 2'b01;
    localparam logic [3:0] CODE_QUERY        = 4'b1000;
    localparam logic [3:0] CODE_QUERY_ADJUST = 4'b1001;
    localparam logic [7:0] CODE_NAK          = 8'hC0;
    localparam logic [7:0] CODE_REQ_RN       = 8'hC1;

    localparam int FLD_RN_LSB            = 104;
    localparam int FLD_SESSION_LSB       = 118;
    localparam int FLD_UPDN_LSB          = 115;
    localparam int FLD_QUERY_SESSION_LSB = 112;
    localparam int FLD_QUERY_Q_LSB       = 107;

    localparam logic [2:0] UPDN_INC  = 3'b110;
    localparam logic [2:0] UPDN_DEC  = 3'b011;
    localparam logic [2:0] UPDN_HOLD = 3'b000;

    localparam logic [14:0] SLOT_MAX = 15'h7FFF;

    // For q=15 the shift overflows to zero and the mask becomes all ones.
    function automatic logic [14:0] slot_from(input logic [15:0] lfsr, input logic [3:0] q);
        return lfsr[14:0] & ((15'd1 << q) - 15'd1);
    endfunction

endpackage

// File: rtl/rfid_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to SEED.
module rfid_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] value
);

    localparam logic [15:0] TAP_MASK = 16'h002D;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= SEED;
        end else begin
            value <= {^(value & TAP_MASK), value[15:1]};
        end
    end

endmodule

// File: rtl/rfid_inv_ctrl.sv
// Gen2 tag inventory controller: slot/Q handling, RN16/handle generation, reply handshake.
// Optional macro RFID_INV_DROP_CNT_EN adds drop_cnt, counting packets dropped while a reply is pending.
module rfid_inv_ctrl
    import rfid_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  Q_RESET   = 4'd0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         pkt_valid,
    input  logic [1:0]   cmd_class,
    input  logic [7:0]   cmd,
    input  logic [119:0] cmd_data,
    output logic         reply_req,
    output logic [1:0]   reply_type,
    output logic [15:0]  reply_data,
    input  logic         reply_ack,
    output logic [2:0]   tag_state,
    output logic [3:0]   q_value,
    output logic [14:0]  slot_cnt
`ifdef RFID_INV_DROP_CNT_EN
    ,
    output logic [7:0]   drop_cnt
`endif
);

    tag_state_t  state;
    cmd_kind_t   cmd_kind;
    logic [1:0]  session;
    logic [15:0] rn16;
    logic [15:0] handle;
    logic [15:0] lfsr;
    logic [3:0]  adj_q;
    logic        adj_valid;
    logic [14:0] query_slot;
    logic [14:0] adj_slot;
    logic [14:0] rep_slot;
    logic        unused_bits;

    wire [15:0] fld_rn            = cmd_data[FLD_RN_LSB +: 16];
    wire [1:0]  fld_session       = cmd_data[FLD_SESSION_LSB +: 2];
    wire [2:0]  fld_updn          = cmd_data[FLD_UPDN_LSB +: 3];
    wire [1:0]  fld_query_session = cmd_data[FLD_QUERY_SESSION_LSB +: 2];
    wire [3:0]  fld_query_q       = cmd_data[FLD_QUERY_Q_LSB +: 4];

    assign unused_bits = ^cmd_data[103:0];
    assign tag_state   = state;

    rfid_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .value   (lfsr)
    );

    always_comb begin
        cmd_kind = CMD_NONE;
        case (cmd_class)
            CLASS_CMD2: begin
                if (cmd[1:0] == CODE_QUERY_REP)   cmd_kind = CMD_QUERY_REP;
                else if (cmd[1:0] == CODE_ACK)    cmd_kind = CMD_ACK;
            end
            CLASS_CMD4: begin
                if (cmd[3:0] == CODE_QUERY)             cmd_kind = CMD_QUERY;
                else if (cmd[3:0] == CODE_QUERY_ADJUST) cmd_kind = CMD_QUERY_ADJUST;
            end
            CLASS_CMD8: begin
                if (cmd == CODE_NAK)         cmd_kind = CMD_NAK;
                else if (cmd == CODE_REQ_RN) cmd_kind = CMD_REQ_RN;
            end
            default: cmd_kind = CMD_NONE;
        endcase
    end

    // Q saturates at both ends; an unknown UpDn code voids the whole QueryAdjust.
    always_comb begin
        adj_valid = 1'b1;
        adj_q     = q_value;
        case (fld_updn)
            UPDN_INC:  if (q_value != 4'hF) adj_q = q_value + 4'd1;
            UPDN_DEC:  if (q_value != 4'h0) adj_q = q_value - 4'd1;
            UPDN_HOLD: adj_q = q_value;
            default:   adj_valid = 1'b0;
        endcase
        query_slot = slot_from(lfsr, fld_query_q);
        adj_slot   = slot_from(lfsr, adj_q);
        rep_slot   = slot_cnt - 15'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_READY;
            q_value    <= Q_RESET;
            slot_cnt   <= '0;
            session    <= '0;
            rn16       <= '0;
            handle     <= '0;
            reply_req  <= 1'b0;
            reply_type <= REPLY_RN16;
            reply_data <= '0;
        end else begin
            if (reply_req && reply_ack) reply_req <= 1'b0;
            if (pkt_valid && !reply_req) begin
                case (cmd_kind)
                    CMD_QUERY: begin
                        session  <= fld_query_session;
                        q_value  <= fld_query_q;
                        slot_cnt <= query_slot;
                        if (query_slot == '0) begin
                            state <= ST_REPLY; rn16 <= lfsr;
                            reply_req <= 1'b1; reply_type <= REPLY_RN16; reply_data <= lfsr;
                        end else begin
                            state <= ST_ARBITRATE;
                        end
                    end
                    CMD_QUERY_ADJUST: begin
                        if (state != ST_READY && fld_session == session && adj_valid) begin
                            q_value  <= adj_q;
                            slot_cnt <= adj_slot;
                            if (adj_slot == '0) begin
                                state <= ST_REPLY; rn16 <= lfsr;
                                reply_req <= 1'b1; reply_type <= REPLY_RN16; reply_data <= lfsr;
                            end else begin
                                state <= ST_ARBITRATE;
                            end
                        end
                    end
                    CMD_QUERY_REP: begin
                        if (fld_session == session) begin
                            if (state == ST_ARBITRATE) begin
                                slot_cnt <= rep_slot;
                                if (rep_slot == '0) begin
                                    state <= ST_REPLY; rn16 <= lfsr;
                                    reply_req <= 1'b1; reply_type <= REPLY_RN16; reply_data <= lfsr;
                                end
                            end else if (state != ST_READY) begin
                                state    <= ST_ARBITRATE;
                                slot_cnt <= SLOT_MAX;
                            end
                        end
                    end
                    CMD_ACK: begin
                        if (state == ST_REPLY || state == ST_ACKNOWLEDGED) begin
                            if (fld_rn == rn16) begin
                                state <= ST_ACKNOWLEDGED;
                                reply_req <= 1'b1; reply_type <= REPLY_EPC; reply_data <= '0;
                            end else begin
                                state <= ST_ARBITRATE;
                            end
                        end else if (state == ST_OPEN) begin
                            if (fld_rn == handle) begin
                                reply_req <= 1'b1; reply_type <= REPLY_EPC; reply_data <= '0;
                            end else begin
                                state <= ST_ARBITRATE;
                            end
                        end
                    end
                    CMD_NAK: begin
                        if (state == ST_REPLY || state == ST_ACKNOWLEDGED || state == ST_OPEN)
                            state <= ST_ARBITRATE;
                    end
                    CMD_REQ_RN: begin
                        if (state == ST_ACKNOWLEDGED && fld_rn == rn16) begin
                            state <= ST_OPEN; handle <= lfsr;
                            reply_req <= 1'b1; reply_type <= REPLY_HANDLE; reply_data <= lfsr;
                        end else if (state == ST_OPEN && fld_rn == handle) begin
                            rn16 <= lfsr;
                            reply_req <= 1'b1; reply_type <= REPLY_RN16; reply_data <= lfsr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RFID_INV_DROP_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (pkt_valid && reply_req && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rfid_inv_ctrl.sv
// Self-checking bench for rfid_inv_ctrl: directed inventory rounds then randomized traffic
// against a behavioural tag model. Honours RFID_INV_DROP_CNT_EN when defined.
module tb_rfid_inv_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int READY = 0, ARB = 1, REPLY = 2, ACKD = 3, OPEN = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [1:0]   cmd_class = '0;
    logic [7:0]   cmd = '0;
    logic [119:0] cmd_data = '0;
    logic         reply_ack = 1'b0;
    logic         reply_req;
    logic [1:0]   reply_type;
    logic [15:0]  reply_data;
    logic [2:0]   tag_state;
    logic [3:0]   q_value;
    logic [14:0]  slot_cnt;
`ifdef RFID_INV_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int          m_state, m_q, m_slot, m_session, m_type, m_drop;
    logic        m_req;
    logic [15:0] m_rn16, m_handle, m_data, m_lfsr;

    rfid_inv_ctrl #(.LFSR_SEED(SEED), .Q_RESET(4'd0)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pkt_valid  (pkt_valid),
        .cmd_class  (cmd_class),
        .cmd        (cmd),
        .cmd_data   (cmd_data),
        .reply_req  (reply_req),
        .reply_type (reply_type),
        .reply_data (reply_data),
        .reply_ack  (reply_ack),
        .tag_state  (tag_state),
        .q_value    (q_value),
        .slot_cnt   (slot_cnt)
`ifdef RFID_INV_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, required normal finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".state"}, 32'(tag_state), 32'(m_state));
        checkOutput({tag, ".q"}, 32'(q_value), 32'(m_q));
        checkOutput({tag, ".slot"}, 32'(slot_cnt), 32'(m_slot));
        checkOutput({tag, ".req"}, 32'(reply_req), 32'(m_req));
        checkOutput({tag, ".type"}, 32'(reply_type), 32'(m_type));
        checkOutput({tag, ".data"}, 32'(reply_data), 32'(m_data));
`ifdef RFID_INV_DROP_CNT_EN
        checkOutput({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        int   taps[4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ v[16 - taps[i]];
        return {fb, v[15:1]};
    endfunction

    task automatic modelReset();
        m_state = READY; m_q = 0; m_slot = 0; m_session = 0; m_drop = 0;
        m_rn16 = '0; m_handle = '0; m_req = 1'b0; m_type = 0; m_data = '0;
        m_lfsr = SEED;
    endtask

    task automatic modelIssue(input int t, input logic [15:0] d);
        m_req = 1'b1; m_type = t; m_data = d;
    endtask

    // A fresh slot is a random number drawn uniformly from 0 .. 2^Q-1.
    task automatic modelReslot(input int q);
        m_slot = int'(m_lfsr & 16'h7FFF) % (1 << q);
        if (m_slot == 0) begin
            m_state = REPLY; m_rn16 = m_lfsr; modelIssue(0, m_lfsr);
        end else begin
            m_state = ARB;
        end
    endtask

    function automatic string decodeName(input logic [1:0] cls, input logic [7:0] c);
        if (cls == 2'd0 && c[1:0] == 2'b00) return "QueryRep";
        if (cls == 2'd0 && c[1:0] == 2'b01) return "ACK";
        if (cls == 2'd1 && c[3:0] == 4'b1000) return "Query";
        if (cls == 2'd1 && c[3:0] == 4'b1001) return "QueryAdjust";
        if (cls == 2'd2 && c == 8'hC0) return "NAK";
        if (cls == 2'd2 && c == 8'hC1) return "ReqRN";
        return "";
    endfunction

    task automatic modelStep(input logic pv, input logic [1:0] cls, input logic [7:0] c,
                             input logic [119:0] d, input logic ack);
        logic        pending;
        string       name;
        logic [15:0] rn;
        int          newq;
        bit          live;
        pending = m_req;
        live = (m_state == REPLY || m_state == ACKD || m_state == OPEN);
        rn = d[119:104];
        if (m_req && ack) m_req = 1'b0;
        if (pv && pending) begin
            if (m_drop < 255) m_drop++;
        end else if (pv) begin
            name = decodeName(cls, c);
            if (name == "Query") begin
                m_session = int'(d[113:112]); m_q = int'(d[110:107]);
                modelReslot(m_q);
            end else if (name == "QueryAdjust") begin
                if (m_state != READY && int'(d[119:118]) == m_session &&
                    (d[117:115] == 3'b110 || d[117:115] == 3'b011 || d[117:115] == 3'b000)) begin
                    newq = m_q;
                    if (d[117:115] == 3'b110) newq = (m_q + 1 > 15) ? 15 : m_q + 1;
                    if (d[117:115] == 3'b011) newq = (m_q - 1 < 0) ? 0 : m_q - 1;
                    m_q = newq;
                    modelReslot(m_q);
                end
            end else if (name == "QueryRep") begin
                if (int'(d[119:118]) == m_session) begin
                    if (m_state == ARB) begin
                        m_slot = (m_slot + 32767) % 32768;
                        if (m_slot == 0) begin
                            m_state = REPLY; m_rn16 = m_lfsr; modelIssue(0, m_lfsr);
                        end
                    end else if (live) begin
                        m_state = ARB; m_slot = 32767;
                    end
                end
            end else if (name == "ACK") begin
                if (m_state == REPLY || m_state == ACKD) begin
                    if (rn == m_rn16) begin m_state = ACKD; modelIssue(1, 16'h0); end
                    else m_state = ARB;
                end else if (m_state == OPEN) begin
                    if (rn == m_handle) modelIssue(1, 16'h0);
                    else m_state = ARB;
                end
            end else if (name == "NAK") begin
                if (live) m_state = ARB;
            end else if (name == "ReqRN") begin
                if (m_state == ACKD && rn == m_rn16) begin
                    m_state = OPEN; m_handle = m_lfsr; modelIssue(2, m_lfsr);
                end else if (m_state == OPEN && rn == m_handle) begin
                    m_rn16 = m_lfsr; modelIssue(0, m_lfsr);
                end
            end
        end
        m_lfsr = lfsrStep(m_lfsr);
    endtask

    task automatic applyStimulus(input string tag, input logic pv, input logic [1:0] cls,
                                 input logic [7:0] c, input logic [119:0] d, input logic ack);
        pkt_valid = pv; cmd_class = cls; cmd = c; cmd_data = d; reply_ack = ack;
        @(posedge clock);
        modelStep(pv, cls, c, d, ack);
        #1;
        checkAll(tag);
        pkt_valid = 1'b0; reply_ack = 1'b0;
    endtask

    function automatic logic [119:0] queryData(input logic [119:0] b, input logic [1:0] s, input logic [3:0] q);
        logic [119:0] d = b;
        d[113:112] = s; d[110:107] = q;
        return d;
    endfunction

    function automatic logic [119:0] adjData(input logic [119:0] b, input logic [1:0] s, input logic [2:0] u);
        logic [119:0] d = b;
        d[119:118] = s; d[117:115] = u;
        return d;
    endfunction

    function automatic logic [119:0] rnData(input logic [119:0] b, input logic [15:0] rn);
        logic [119:0] d = b;
        d[119:104] = rn;
        return d;
    endfunction

    task automatic sendQuery(input string t, input logic [1:0] s, input logic [3:0] q);
        applyStimulus(t, 1'b1, 2'd1, 8'h08, queryData('0, s, q), 1'b0);
    endtask
    task automatic sendRep(input string t, input logic [1:0] s);
        applyStimulus(t, 1'b1, 2'd0, 8'h00, adjData('0, s, 3'b000), 1'b0);
    endtask
    task automatic sendAdj(input string t, input logic [1:0] s, input logic [2:0] u);
        applyStimulus(t, 1'b1, 2'd1, 8'h09, adjData('0, s, u), 1'b0);
    endtask
    task automatic sendAck(input string t, input logic [15:0] rn);
        applyStimulus(t, 1'b1, 2'd0, 8'h01, rnData('0, rn), 1'b0);
    endtask
    task automatic sendReqRn(input string t, input logic [15:0] rn);
        applyStimulus(t, 1'b1, 2'd2, 8'hC1, rnData('0, rn), 1'b0);
    endtask
    task automatic sendNak(input string t);
        applyStimulus(t, 1'b1, 2'd2, 8'hC0, '0, 1'b0);
    endtask
    task automatic ackReply(input string t);
        applyStimulus(t, 1'b0, 2'd0, 8'h00, '0, 1'b1);
    endtask
    task automatic drain(input string t);
        if (m_req) ackReply(t);
    endtask

    initial begin
        int           n;
        int           kind;
        logic [127:0] r;
        logic [119:0] base;
        logic [15:0]  rn;
        logic [1:0]   s;
        logic [2:0]   u;

        // Reset state
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkAll("reset");
        reset_n = 1'b1;

        // Query Q=0 always lands in slot 0 and backscatters RN16
        sendQuery("query_q0", 2'd0, 4'd0);
        ackReply("ack_rn16");

        // Wait for an LFSR value whose low bits give slot 3 under Q=2
        n = 0;
        while ((m_lfsr & 16'h3) != 16'h3 && n < 200) begin
            applyStimulus("idle", 1'b0, 2'd0, 8'h00, '0, 1'b0);
            n++;
        end
        checkOutput("lfsr_wait", 32'((m_lfsr & 16'h3) == 16'h3), 32'd1);
        sendQuery("query_q2", 2'd0, 4'd2);
        checkOutput("slot3", 32'(slot_cnt), 32'd3);
        sendRep("rep1", 2'd0);
        sendRep("rep2", 2'd0);
        sendRep("rep3", 2'd0);
        checkOutput("rep3_reply", 32'(tag_state), 32'(REPLY));
        ackReply("ack_rep3");

        // ACK / ReqRN / handle path
        sendAck("ack_match", m_rn16);
        ackReply("ack_epc");
        sendAck("ack_again", m_rn16);
        ackReply("ack_epc2");
        sendReqRn("reqrn_open", m_rn16);
        checkOutput("open_state", 32'(tag_state), 32'(OPEN));
        ackReply("ack_handle");
        sendAck("ack_handle_epc", m_handle);
        ackReply("ack_epc3");
        sendReqRn("reqrn_new_rn16", m_handle);
        ackReply("ack_new_rn16");
        sendNak("nak");
        sendQuery("query_again", 2'd0, 4'd0);
        ackReply("ack_again_rn16");
        sendAck("ack_mismatch", m_rn16 ^ 16'h0001);
        checkOutput("mismatch_arb", 32'(tag_state), 32'(ARB));

        // Q saturation and session mismatch
        sendQuery("query_q15", 2'd0, 4'd15);
        drain("drain_q15");
        sendAdj("adj_up_sat", 2'd0, 3'b110);
        checkOutput("q_sat_hi", 32'(q_value), 32'd15);
        drain("drain_adj_up");
        sendQuery("query_q0b", 2'd0, 4'd0);
        ackReply("ack_q0b");
        sendAdj("adj_dn_sat", 2'd0, 3'b011);
        checkOutput("q_sat_lo", 32'(q_value), 32'd0);
        drain("drain_adj_dn");
        sendAdj("adj_sess_mismatch", 2'd1, 3'b110);
        sendAdj("adj_bad_updn", 2'd0, 3'b111);
        sendRep("rep_sess_mismatch", 2'd2);

        // Packet arriving while a reply is pending is dropped
        sendQuery("query_pend", 2'd0, 4'd0);
        sendQuery("query_dropped", 2'd1, 4'd5);
        ackReply("ack_after_drop");
        checkOutput("req_cleared", 32'(reply_req), 32'd0);

        // Asynchronous reset in the middle of a handshake
        sendQuery("query_pre_reset", 2'd0, 4'd0);
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        checkAll("async_reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            base = r[119:0];
            s = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_session);
            case ($urandom_range(0, 3))
                0: rn = m_rn16;
                1: rn = m_handle;
                2: rn = 16'($urandom);
                default: rn = m_rn16 ^ (16'd1 << $urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 3))
                0: u = 3'b110;
                1: u = 3'b011;
                2: u = 3'b000;
                default: u = 3'($urandom);
            endcase
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 0) kind = 9;
            case (kind)
                0: applyStimulus("rnd_query", 1'b1, 2'd1, 8'h08,
                       queryData(base, s, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2))),
                       $urandom_range(0, 2) == 0);
                1, 2: applyStimulus("rnd_rep", 1'b1, 2'd0, 8'h00, adjData(base, s, u), $urandom_range(0, 2) == 0);
                3: applyStimulus("rnd_adj", 1'b1, 2'd1, 8'h09, adjData(base, s, u), $urandom_range(0, 2) == 0);
                4: applyStimulus("rnd_ack", 1'b1, 2'd0, 8'h01, rnData(base, rn), $urandom_range(0, 2) == 0);
                5: applyStimulus("rnd_nak", 1'b1, 2'd2, 8'hC0, base, $urandom_range(0, 2) == 0);
                6: applyStimulus("rnd_reqrn", 1'b1, 2'd2, 8'hC1, rnData(base, rn), $urandom_range(0, 2) == 0);
                7: applyStimulus("rnd_invalid", 1'b1, 2'd3, 8'($urandom), base, $urandom_range(0, 2) == 0);
                8: applyStimulus("rnd_badcode", 1'b1, 2'd2, 8'($urandom_range(0, 191)), base, $urandom_range(0, 2) == 0);
                default: applyStimulus("rnd_idle", 1'b0, 2'd0, 8'h00, base, $urandom_range(0, 2) == 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
